// File: rtl/ddr4_rank_cmd_sched.sv
// DDR4 single-rank command sequencer: power-up/init (RESET_n, CKE, MRS x7, ZQCL), periodic
// PREA+REF refresh, and valid/ready forwarding of single ACT/RD/WR/PRE commands to the side-A bus.
module ddr4_rank_cmd_sched #(
  parameter int          MC_ABITS      = 18,
  parameter int          MC_BANK_WIDTH = 2,
  parameter int          MC_BANK_GROUP = 2,
  parameter int          T_RESET       = 200,
  parameter int          T_CKE         = 500,
  parameter int          T_XPR         = 64,
  parameter int          T_MRD         = 8,
  parameter int          T_MOD         = 24,
  parameter int          T_ZQINIT      = 1024,
  parameter int          T_REFI        = 7800,
  parameter int          T_RP          = 16,
  parameter int          T_RFC         = 350,
  parameter logic [13:0] MR0           = 14'h0,
  parameter logic [13:0] MR1           = 14'h0,
  parameter logic [13:0] MR2           = 14'h0,
  parameter logic [13:0] MR3           = 14'h0,
  parameter logic [13:0] MR4           = 14'h0,
  parameter logic [13:0] MR5           = 14'h0,
  parameter logic [13:0] MR6           = 14'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_type,
  input  logic [MC_BANK_GROUP-1:0] cmd_bg,
  input  logic [MC_BANK_WIDTH-1:0] cmd_ba,
  input  logic [MC_ABITS-1:0]      cmd_addr,
  output logic                     ddr_reset_n,
  output logic                     ddr_cke,
  output logic                     ddr_cs_n,
  output logic                     ddr_act_n,
  output logic [MC_ABITS-1:0]      ddr_addr,
  output logic [MC_BANK_WIDTH-1:0] ddr_ba,
  output logic [MC_BANK_GROUP-1:0] ddr_bg,
  output logic                     ddr_odt,
  output logic                     ddr_par,
  output logic                     init_done,
  output logic                     ref_overrun
);
  typedef enum logic [2:0] {RST_HOLD, CKE_LOW, XPR, MRS, ZQ, IDLE, PREA, REF} state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int WAIT_MAX = max_of(max_of(max_of(T_RESET, T_CKE), max_of(T_XPR, T_MRD)),
                                   max_of(max_of(T_MOD, T_ZQINIT), max_of(T_RP, T_RFC)));
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam int RW = $clog2(T_REFI + 1);

  // Opcodes carried on A16..A14 by the non-ACT commands.
  localparam logic [2:0] OP_MRS = 3'b000, OP_REF = 3'b001, OP_PRE = 3'b010;
  localparam logic [2:0] OP_WR = 3'b100, OP_RD = 3'b101, OP_ZQ = 3'b110;

  // Mode registers go out in the order MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  function automatic logic [2:0] mr_num(input logic [2:0] pos);
    case (pos)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [13:0] mr_payload(input logic [2:0] num);
    case (num)
      3'd1:    return MR1;
      3'd2:    return MR2;
      3'd3:    return MR3;
      3'd4:    return MR4;
      3'd5:    return MR5;
      3'd6:    return MR6;
      default: return MR0;
    endcase
  endfunction

  state_t                   state_reg, state_next;
  logic [CW-1:0]            cnt_reg, cnt_next, wait_len;
  logic [2:0]               mrs_pos_reg, mrs_pos_next;
  logic [RW-1:0]            refi_cnt_reg, refi_cnt_next;
  logic                     ref_pending_reg, ref_pending_next;
  logic                     wait_done, accept, refi_expire, ref_clear, init_done_next;
  logic                     is_cmd, act_n_next, odt_next, par_next, ready_next;
  logic [MC_ABITS-1:0]      addr_next;
  logic [MC_BANK_WIDTH-1:0] ba_next;
  logic [MC_BANK_GROUP-1:0] bg_next;
  logic [MC_BANK_WIDTH:0]   mr_sel;

  assign accept           = cmd_valid & cmd_ready;
  assign wait_done        = (cnt_reg == wait_len - 1'b1);
  assign refi_expire      = init_done && (refi_cnt_reg == RW'(T_REFI - 1));
  assign ref_clear        = (state_reg == REF) && wait_done;
  assign ref_pending_next = refi_expire | (ref_pending_reg & ~ref_clear);
  assign init_done_next   = init_done | ((state_reg == ZQ) && wait_done);
  assign refi_cnt_next    = (!init_done || refi_expire) ? '0 : refi_cnt_reg + 1'b1;

  always_comb begin
    wait_len = '0;
    case (state_reg)
      RST_HOLD: wait_len = CW'(T_RESET);
      CKE_LOW:  wait_len = CW'(T_CKE);
      XPR:      wait_len = CW'(T_XPR);
      MRS:      wait_len = (mrs_pos_reg == 3'd6) ? CW'(T_MOD) : CW'(T_MRD);
      ZQ:       wait_len = CW'(T_ZQINIT);
      PREA:     wait_len = CW'(T_RP);
      REF:      wait_len = CW'(T_RFC);
      default:  wait_len = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RST_HOLD;
      cnt_reg         <= '0;
      mrs_pos_reg     <= '0;
      refi_cnt_reg    <= '0;
      ref_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      mrs_pos_reg     <= mrs_pos_next;
      refi_cnt_reg    <= refi_cnt_next;
      ref_pending_reg <= ref_pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mrs_pos_next = mrs_pos_reg;
    cnt_next     = cnt_reg + 1'b1;
    case (state_reg)
      RST_HOLD: if (wait_done) state_next = CKE_LOW;
      CKE_LOW:  if (wait_done) state_next = XPR;
      XPR:      if (wait_done) state_next = MRS;
      MRS: begin
        if (wait_done) begin
          if (mrs_pos_reg == 3'd6) state_next = ZQ;
          else                     mrs_pos_next = mrs_pos_reg + 3'd1;
        end
      end
      ZQ:       if (wait_done) state_next = IDLE;
      IDLE:     if (ref_pending_reg) state_next = PREA;
      PREA:     if (wait_done) state_next = REF;
      REF:      if (wait_done) state_next = IDLE;
      default:  state_next = RST_HOLD;
    endcase
    // Every slot restarts its span counter, so a command always lands on count zero.
    if (wait_done || state_next != state_reg || state_next == IDLE) cnt_next = '0;
  end

  always_comb begin
    is_cmd     = 1'b0;
    act_n_next = 1'b1;
    addr_next  = '0;
    ba_next    = '0;
    bg_next    = '0;
    odt_next   = 1'b0;
    mr_sel     = (MC_BANK_WIDTH + 1)'(mr_num(mrs_pos_next));
    if (cnt_next == '0) begin
      case (state_next)
        MRS: begin
          is_cmd                   = 1'b1;
          addr_next[13:0]          = mr_payload(mr_num(mrs_pos_next));
          addr_next[16:14]         = OP_MRS;
          ba_next                  = mr_sel[MC_BANK_WIDTH-1:0];
          bg_next[0]               = mr_sel[MC_BANK_WIDTH];
        end
        ZQ:   begin is_cmd = 1'b1; addr_next[16:14] = OP_ZQ;  addr_next[10] = 1'b1; end
        PREA: begin is_cmd = 1'b1; addr_next[16:14] = OP_PRE; addr_next[10] = 1'b1; end
        REF:  begin is_cmd = 1'b1; addr_next[16:14] = OP_REF; end
        default: ;
      endcase
    end
    if (accept) begin
      is_cmd   = 1'b1;
      ba_next  = cmd_ba;
      bg_next  = cmd_bg;
      odt_next = (cmd_type == 2'd2);
      if (cmd_type == 2'd0) begin
        act_n_next = 1'b0;
        addr_next  = cmd_addr;
      end else begin
        addr_next[13:0]  = cmd_addr[13:0];
        addr_next[16:14] = (cmd_type == 2'd1) ? OP_RD : (cmd_type == 2'd2) ? OP_WR : OP_PRE;
      end
    end
    par_next   = is_cmd & (^{act_n_next, addr_next, ba_next, bg_next});
    ready_next = (state_next == IDLE) && !ref_pending_next && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_reset_n <= 1'b0;
      ddr_cke     <= 1'b0;
      ddr_cs_n    <= 1'b1;
      ddr_act_n   <= 1'b1;
      ddr_addr    <= '0;
      ddr_ba      <= '0;
      ddr_bg      <= '0;
      ddr_odt     <= 1'b0;
      ddr_par     <= 1'b0;
      init_done   <= 1'b0;
      cmd_ready   <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      ddr_reset_n <= (state_next != RST_HOLD);
      ddr_cke     <= (state_next != RST_HOLD) && (state_next != CKE_LOW);
      ddr_cs_n    <= ~is_cmd;
      ddr_act_n   <= act_n_next;
      ddr_addr    <= addr_next;
      ddr_ba      <= ba_next;
      ddr_bg      <= bg_next;
      ddr_odt     <= odt_next;
      ddr_par     <= par_next;
      init_done   <= init_done_next;
      cmd_ready   <= ready_next;
      ref_overrun <= refi_expire & ref_pending_reg;
    end
  end
endmodule

// File: tb/tb_ddr4_rank_cmd_sched.sv
// Randomized bench: a timeline model of init, refresh and command forwarding is compared every cycle
// against two instances, one with a normal tREFI and one whose tREFI is shorter than PREA+REF.
module tb_ddr4_rank_cmd_sched;
  localparam int TR = 4, TC = 6, TX = 3, TMRD = 2, TMOD = 4, TZQ = 10;
  localparam int TREFI = 100, TREFI_OV = 10, TRP = 3, TRFC = 8;
  localparam logic [13:0] MRV0 = 14'h0123, MRV1 = 14'h0456, MRV2 = 14'h0789, MRV3 = 14'h0abc;
  localparam logic [13:0] MRV4 = 14'h0def, MRV5 = 14'h1234, MRV6 = 14'h1567;

  typedef struct packed {
    logic        reset_n;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [17:0] addr;
    logic [1:0]  ba;
    logic [1:0]  bg;
    logic        odt;
    logic        par;
    logic        init_done;
    logic        ready;
    logic        overrun;
  } bus_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = '0, cmd_bg = '0, cmd_ba = '0;
  logic [17:0] cmd_addr = '0;

  logic        ready_w [2], reset_n_w [2], cke_w [2], cs_n_w [2], act_n_w [2];
  logic        odt_w [2], par_w [2], init_done_w [2], overrun_w [2];
  logic [17:0] addr_w [2];
  logic [1:0]  ba_w [2], bg_w [2];

  int          k = 0, checks = 0, fails = 0, ov_seen = 0, ov_exp = 0;
  int          mr_order [7] = '{3, 6, 5, 4, 2, 1, 0};
  logic [13:0] mr_val [7] = '{MRV0, MRV1, MRV2, MRV3, MRV4, MRV5, MRV6};
  bit          m_pending [2], m_ready [2];
  int          m_prea [2], m_refe [2], m_clr [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ddr4_rank_cmd_sched #(
      .MC_ABITS(18), .MC_BANK_WIDTH(2), .MC_BANK_GROUP(2),
      .T_RESET(TR), .T_CKE(TC), .T_XPR(TX), .T_MRD(TMRD), .T_MOD(TMOD), .T_ZQINIT(TZQ),
      .T_REFI(gi == 0 ? TREFI : TREFI_OV), .T_RP(TRP), .T_RFC(TRFC),
      .MR0(MRV0), .MR1(MRV1), .MR2(MRV2), .MR3(MRV3), .MR4(MRV4), .MR5(MRV5), .MR6(MRV6)
    ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_w[gi]),
      .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
      .ddr_reset_n(reset_n_w[gi]), .ddr_cke(cke_w[gi]), .ddr_cs_n(cs_n_w[gi]),
      .ddr_act_n(act_n_w[gi]), .ddr_addr(addr_w[gi]), .ddr_ba(ba_w[gi]), .ddr_bg(bg_w[gi]),
      .ddr_odt(odt_w[gi]), .ddr_par(par_w[gi]), .init_done(init_done_w[gi]),
      .ref_overrun(overrun_w[gi])
    );
  end

  // Expected bus after edge k, from the absolute timeline of init and the refresh schedule.
  task automatic model(input int d, output bus_t e);
    int mrs0, zq, i0, trefi;
    bit accept, expire;
    mrs0  = TR + TC + TX;
    zq    = mrs0 + 6 * TMRD + TMOD;
    i0    = zq + TZQ;
    trefi = (d == 0) ? TREFI : TREFI_OV;
    e         = '0;
    e.cs_n    = 1'b1;
    e.act_n   = 1'b1;
    e.reset_n = (k >= TR);
    e.cke     = (k >= TR + TC);
    for (int i = 0; i < 7; i++) begin
      if (k == mrs0 + i * TMRD) begin
        e.cs_n = 1'b0;
        e.addr = {4'b0, mr_val[mr_order[i]]};
        e.ba   = 2'(mr_order[i] % 4);
        e.bg   = 2'(mr_order[i] / 4);
      end
    end
    if (k == zq) begin e.cs_n = 1'b0; e.addr = 18'h18400; end
    e.init_done = (k >= i0);
    if (k >= i0) begin
      accept    = cmd_valid && m_ready[d];
      expire    = (k > i0) && ((k - i0) % trefi == 0);
      e.overrun = expire && m_pending[d];
      if (m_pending[d] && k == m_clr[d]) m_pending[d] = 1'b0;
      if (expire && !m_pending[d]) begin
        m_pending[d] = 1'b1;
        m_prea[d]    = k + 1;
        m_refe[d]    = k + 1 + TRP;
        m_clr[d]     = k + 1 + TRP + TRFC;
      end
      if (k == m_prea[d]) begin
        e.cs_n = 1'b0; e.addr = 18'h08400;
      end else if (k == m_refe[d]) begin
        e.cs_n = 1'b0; e.addr = 18'h04000;
      end else if (accept) begin
        e.cs_n = 1'b0;
        e.ba   = cmd_ba;
        e.bg   = cmd_bg;
        e.odt  = (cmd_type == 2'd2);
        case (cmd_type)
          2'd0:    begin e.act_n = 1'b0; e.addr = cmd_addr; end
          2'd1:    e.addr = 18'h14000 | {4'b0, cmd_addr[13:0]};
          2'd2:    e.addr = 18'h10000 | {4'b0, cmd_addr[13:0]};
          default: e.addr = 18'h08000 | {4'b0, cmd_addr[13:0]};
        endcase
      end
      m_ready[d] = !m_pending[d] && !accept;
      e.ready    = m_ready[d];
    end
    if (!e.cs_n) e.par = ^{e.act_n, e.addr, e.ba, e.bg};
  endtask

  task automatic check(input string tag, input int d);
    bus_t e, a;
    model(d, e);
    a = {reset_n_w[d], cke_w[d], cs_n_w[d], act_n_w[d], addr_w[d], ba_w[d], bg_w[d],
         odt_w[d], par_w[d], init_done_w[d], ready_w[d], overrun_w[d]};
    if (d == 1) begin ov_seen += int'(a.overrun); ov_exp += int'(e.overrun); end
    checks++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s%0d k=%0d got=%h exp=%h", tag, d, k, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("bus", d);
  endtask

  task automatic apply_reset(input int hold);
    #2 rst = 1'b1;
    cmd_valid = 1'b0;
    k = 0;
    for (int d = 0; d < 2; d++) begin
      m_pending[d] = 1'b0; m_ready[d] = 1'b0;
      m_prea[d] = -1; m_refe[d] = -1; m_clr[d] = -1;
    end
    #1;
    for (int d = 0; d < 2; d++) check("rst_async", d);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rst_hold", d);
    rst = 1'b0;
  endtask

  initial begin
    // Power-up init, then the first refresh with no traffic.
    apply_reset(2);
    repeat (150) step();

    // Single ACT bg=1 ba=2 row 0x1234.
    for (int i = 0; i < 30 && !m_ready[0]; i++) step();
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_bg = 2'd1; cmd_ba = 2'd2; cmd_addr = 18'h01234;
    step();
    cmd_valid = 1'b0;
    checks++;
    assert ({cs_n_w[0], act_n_w[0], addr_w[0], ba_w[0], bg_w[0]} === {2'b00, 18'h01234, 2'd2, 2'd1})
      else begin
        fails++;
        $error("FAIL act_bus got=%h exp=%h", {cs_n_w[0], act_n_w[0], addr_w[0], ba_w[0], bg_w[0]},
               {2'b00, 18'h01234, 2'd2, 2'd1});
      end
    step();

    // Back-to-back RD requests held valid across a refresh.
    cmd_valid = 1'b1; cmd_type = 2'd1;
    for (int i = 0; i < 130; i++) begin
      cmd_addr = 18'($urandom); cmd_ba = 2'($urandom); cmd_bg = 2'($urandom);
      step();
    end

    // Random traffic of all command types.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_type  = 2'($urandom); cmd_bg = 2'($urandom); cmd_ba = 2'($urandom);
      cmd_addr  = 18'($urandom);
      step();
    end
    cmd_valid = 1'b0;

    // Reset in the middle of a REF wait.
    begin
      int budget = 0;
      while (k != m_refe[0] + 2 && budget < 300) begin step(); budget++; end
      checks++;
      assert (budget < 300) else begin
        fails++;
        $error("FAIL wait_ref k=%0d got=timeout exp=REF_issued", k);
      end
    end
    apply_reset(1);

    // Reset in the middle of the MRS sequence, then a full init again.
    repeat (18) step();
    apply_reset(1);
    repeat (160) step();

    checks++;
    assert (ov_seen === ov_exp && ov_exp > 0) else begin
      fails++;
      $error("FAIL overrun_count got=%0d exp=%0d", ov_seen, ov_exp);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
